multicycle_control: RTL and testbench

- Multi-cycle MIPS main control unit: FSM sequencing each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select and enable: PC, IR, register file, ALU muxes and shared instruction/data memory.
- Supports R-type, addi, lw, sw, beq and j.
- Stalls on a memory-ready handshake and reports instruction retirement and illegal opcodes.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// master = controller (drives selects/enables), slave = datapath (supplies opcode and memory ready).
interface multicycle_control_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    Op_i;
  logic               mem_ready_i;
  logic               PCWrite_o;
  logic               PCWriteCond_o;
  logic               IorD_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               IRWrite_o;
  logic               MemtoReg_o;
  logic               RegDst_o;
  logic               RegWrite_o;
  logic               ALUSrcA_o;
  logic [1:0]         ALUSrcB_o;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic [1:0]         PCSource_o;
  logic [3:0]         state_o;
  logic               done_o;
  logic               illegal_o;

  modport master (
    input  Op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, state_o, done_o, illegal_o
  );

  modport slave (
    output Op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
           PCSource_o, state_o, done_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM; outputs decoded from the current state (j/beq 3, R/addi/sw 4, lw 5 cycles).
// Memory accesses stall in FETCH/MEMRD/MEMWR until mem_ready_i; strobes that commit results wait for it too.
module multicycle_control #(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 2,
  parameter int ALUOP_ADD   = 0,
  parameter int ALUOP_SUB   = 1,
  parameter int ALUOP_FUNCT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master bus
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic               pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic               mem_to_reg, reg_dst, reg_write, alu_src_a, done, illegal;
  logic [1:0]         alu_src_b, pc_source;
  logic [ALUOP_W-1:0] alu_op;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALUOP_W'(ALUOP_ADD);
    pc_source     = 2'd0;
    done          = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = bus.mem_ready_i;
        pc_write  = bus.mem_ready_i;
        state_d   = bus.mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively, before the opcode is known.
        alu_src_b = 2'd3;
        case (bus.Op_i)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (bus.Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = bus.mem_ready_i ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = bus.mem_ready_i;
        state_d   = bus.mem_ready_i ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALUOP_FUNCT);
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALUOP_SUB);
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        done          = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        done      = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Holding reset suppresses every strobe immediately, so an aborted instruction never writes.
    if (!rst_i) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = '0;
      pc_source     = 2'd0;
      done          = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign bus.PCWrite_o     = pc_write;
  assign bus.PCWriteCond_o = pc_write_cond;
  assign bus.IorD_o        = iord;
  assign bus.MemRead_o     = mem_read;
  assign bus.MemWrite_o    = mem_write;
  assign bus.IRWrite_o     = ir_write;
  assign bus.MemtoReg_o    = mem_to_reg;
  assign bus.RegDst_o      = reg_dst;
  assign bus.RegWrite_o    = reg_write;
  assign bus.ALUSrcA_o     = alu_src_a;
  assign bus.ALUSrcB_o     = alu_src_b;
  assign bus.ALUOp_o       = alu_op;
  assign bus.PCSource_o    = pc_source;
  assign bus.state_o       = state_q;
  assign bus.done_o        = done;
  assign bus.illegal_o     = illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: compares state plus every control output, cycle by cycle.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  multicycle_control_if #(.OP_W(6), .ALUOP_W(2)) m ();

  multicycle_control #(
    .OP_W(6), .ALUOP_W(2), .ALUOP_ADD(0), .ALUOP_SUB(1), .ALUOP_FUNCT(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Field order: state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  // MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, done, illegal.
  localparam logic [21:0] X_FETCH_R = {4'd0,  10'b1001010000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_FETCH_W = {4'd0,  10'b0001000000, 2'd1, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_DEC     = {4'd1,  10'b0000000000, 2'd3, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_DEC_ILL = {4'd1,  10'b0000000000, 2'd3, 2'd0, 2'd0, 2'b01};
  localparam logic [21:0] X_MEMADDR = {4'd2,  10'b0000000001, 2'd2, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_MEMRD   = {4'd3,  10'b0011000000, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_MEMWB   = {4'd4,  10'b0000001010, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [21:0] X_MEMWR_W = {4'd5,  10'b0010100000, 2'd0, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_MEMWR_R = {4'd5,  10'b0010100000, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [21:0] X_EXEC    = {4'd6,  10'b0000000001, 2'd0, 2'd2, 2'd0, 2'b00};
  localparam logic [21:0] X_RWB     = {4'd7,  10'b0000000110, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [21:0] X_BRANCH  = {4'd8,  10'b0100000001, 2'd0, 2'd1, 2'd1, 2'b10};
  localparam logic [21:0] X_JUMP    = {4'd9,  10'b1000000000, 2'd0, 2'd0, 2'd2, 2'b10};
  localparam logic [21:0] X_IEXEC   = {4'd10, 10'b0000000001, 2'd2, 2'd0, 2'd0, 2'b00};
  localparam logic [21:0] X_IWB     = {4'd11, 10'b0000000010, 2'd0, 2'd0, 2'd0, 2'b10};
  localparam logic [21:0] X_ZERO_S0 = {4'd0,  18'b0};
  localparam logic [21:0] X_ZERO_S3 = {4'd3,  18'b0};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  function automatic logic [21:0] obs();
    return {m.state_o, m.PCWrite_o, m.PCWriteCond_o, m.IorD_o, m.MemRead_o,
            m.MemWrite_o, m.IRWrite_o, m.MemtoReg_o, m.RegDst_o, m.RegWrite_o,
            m.ALUSrcA_o, m.ALUSrcB_o, m.ALUOp_o, m.PCSource_o, m.done_o, m.illegal_o};
  endfunction

  task automatic test_reset();
    rst = 1'b0; m.Op_i = OP_LW; m.mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (obs() !== X_ZERO_S0) begin
      tests_failed++;
      $display("FAIL reset_hold got %h exp %h", obs(), X_ZERO_S0);
    end
    rst = 1'b1; #1;
    tests_run++;
    if (obs() !== X_FETCH_R) begin
      tests_failed++;
      $display("FAIL reset_release got %h exp %h", obs(), X_FETCH_R);
    end
  endtask

  task automatic test_lw();
    logic [21:0] exp_v [5];
    exp_v = '{X_FETCH_R, X_DEC, X_MEMADDR, X_MEMRD, X_MEMWB};
    for (int i = 0; i < 5; i++) begin
      m.Op_i = OP_LW; m.mem_ready_i = 1'b1; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL lw cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (m.state_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL lw_return state got %0d exp 0", m.state_o);
    end
  endtask

  task automatic test_r_stall();
    logic [21:0] exp_v [6];
    logic        rdy_v [6];
    exp_v = '{X_FETCH_W, X_FETCH_W, X_FETCH_R, X_DEC, X_EXEC, X_RWB};
    rdy_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      m.Op_i = OP_R; m.mem_ready_i = rdy_v[i]; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL r_stall cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    logic [21:0] exp_v [7];
    logic        rdy_v [7];
    exp_v = '{X_FETCH_R, X_DEC, X_MEMADDR, X_MEMWR_W, X_MEMWR_W, X_MEMWR_W, X_MEMWR_R};
    rdy_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      m.Op_i = OP_SW; m.mem_ready_i = rdy_v[i]; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL sw_stall cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (m.state_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL sw_return state got %0d exp 0", m.state_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_v [6];
    logic [5:0]  op_v [6];
    exp_v = '{X_FETCH_R, X_DEC, X_BRANCH, X_FETCH_R, X_DEC, X_JUMP};
    op_v  = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    for (int i = 0; i < 6; i++) begin
      m.Op_i = op_v[i]; m.mem_ready_i = 1'b1; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL beq_j cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_then_addi();
    logic [21:0] exp_v [6];
    logic [5:0]  op_v [6];
    exp_v = '{X_FETCH_R, X_DEC_ILL, X_FETCH_R, X_DEC, X_IEXEC, X_IWB};
    op_v  = '{OP_BAD, OP_BAD, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    for (int i = 0; i < 6; i++) begin
      m.Op_i = op_v[i]; m.mem_ready_i = 1'b1; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL illegal_addi cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] exp_v [3];
    exp_v = '{X_FETCH_R, X_DEC, X_MEMADDR};
    for (int i = 0; i < 3; i++) begin
      m.Op_i = OP_LW; m.mem_ready_i = 1'b1; #1;
      tests_run++;
      if (obs() !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL rst_mid_pre cyc%0d got %h exp %h", i, obs(), exp_v[i]);
      end
      @(posedge clk); #1;
    end
    m.mem_ready_i = 1'b0; #1;
    tests_run++;
    if (obs() !== X_MEMRD) begin
      tests_failed++;
      $display("FAIL rst_mid_memrd got %h exp %h", obs(), X_MEMRD);
    end
    rst = 1'b0; m.mem_ready_i = 1'b1; #1;
    tests_run++;
    if (obs() !== X_ZERO_S3) begin
      tests_failed++;
      $display("FAIL rst_mid_forced got %h exp %h", obs(), X_ZERO_S3);
    end
    @(posedge clk); #1;
    tests_run++;
    if (obs() !== X_ZERO_S0) begin
      tests_failed++;
      $display("FAIL rst_mid_edge got %h exp %h", obs(), X_ZERO_S0);
    end
    rst = 1'b1; #1;
    tests_run++;
    if (obs() !== X_FETCH_R) begin
      tests_failed++;
      $display("FAIL rst_mid_fetch got %h exp %h", obs(), X_FETCH_R);
    end
    @(posedge clk); #1;
    tests_run++;
    if (obs() !== X_DEC) begin
      tests_failed++;
      $display("FAIL rst_mid_decode got %h exp %h", obs(), X_DEC);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    m.Op_i        = 6'b0;
    m.mem_ready_i = 1'b0;
    test_reset();
    test_lw();
    test_r_stall();
    test_sw_stall();
    test_back_to_back();
    test_illegal_then_addi();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
